// File: rtl/lpc_frame_buffer_if.sv
// lpc_frame_buffer_if
//   Groups the decoded-LPC capture bus and the drain-stage read/release port
//   of lpc_frame_buffer.
//   slave  : the frame buffer (receives LPC cycles, serves frame bytes)
//   master : the environment (LPC decoder plus serializer drain stage)
// Signals:
//   lpc_valid, lpc_cyctype_dir[3:0], lpc_addr[31:0], lpc_data[7:0] : decoded cycle
//   read_addr[AW-1:0], read_data[7:0]                             : byte read port
//   target_addr[AW-4:0], read_empty, read_done                     : frame hand-off
//   overflow, dropped_count[7:0]                                   : loss reporting
interface lpc_frame_buffer_if #(
  parameter int AW = 8
);
  logic          lpc_valid;
  logic [3:0]    lpc_cyctype_dir;
  logic [31:0]   lpc_addr;
  logic [7:0]    lpc_data;
  logic [AW-1:0] read_addr;
  logic [7:0]    read_data;
  logic [AW-4:0] target_addr;
  logic          read_empty;
  logic          read_done;
  logic          overflow;
  logic [7:0]    dropped_count;

  modport slave (
    input  lpc_valid, lpc_cyctype_dir, lpc_addr, lpc_data,
    input  read_addr, read_done,
    output read_data, target_addr, read_empty, overflow, dropped_count
  );

  modport master (
    output lpc_valid, lpc_cyctype_dir, lpc_addr, lpc_data,
    output read_addr, read_done,
    input  read_data, target_addr, read_empty, overflow, dropped_count
  );
endinterface

// File: rtl/lpc_frame_buffer.sv
// lpc_frame_buffer
//   Stores every accepted LPC cycle as an 8-byte frame in a ring of
//   2^(AW-3) slots and presents the oldest committed frame to the drain
//   stage. Cycles arriving while the ring is full or while a frame is still
//   being written are dropped, counted (saturating) and flagged.
// Ports:
//   clock  : single clock
//   reset  : synchronous, active-high
//   bus    : lpc_frame_buffer_if.slave (LPC capture + drain read/release)
// Optional build macro:
//   LPC_FRAME_SEQ_EN : when defined, byte 6 of each frame carries an 8-bit
//                      sequence number that advances on every lpc_valid,
//                      dropped cycles included; otherwise byte 6 is 8'h00.
module lpc_frame_buffer #(
  parameter int AW = 8
) (
  input  logic               clock,
  input  logic               reset,
  lpc_frame_buffer_if.slave  bus
);

  localparam int PW = AW - 2;  // slot index plus wrap bit
  localparam int SW = AW - 3;  // slot index
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [3:0]    cyc_q;
  logic [31:0]   addr_q;
  logic [7:0]    data_q;
  logic          ovf_mark_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          read_done_q;
  logic          overflow_q;
  logic [7:0]    dropped_q;
  logic [7:0]    read_data_q;
  logic [7:0]    ram_q [0:(1<<AW)-1];

  logic          release_s;
  logic          commit_s;
  logic          accept_s;
  logic          drop_s;
  logic          ram_we_s;
  logic [AW-1:0] wr_addr_s;
  logic [7:0]    wr_byte_s;
  logic [7:0]    seq_byte_s;

`ifdef LPC_FRAME_SEQ_EN
  logic [7:0]    seq_cnt_q;
  logic [7:0]    seq_q;
  assign seq_byte_s = seq_q;
`else
  assign seq_byte_s = 8'h00;
`endif

  // Decode this cycle's accept/drop/commit/release events and next pointers.
  always_comb begin
    release_s = bus.read_done & ~read_done_q & ~empty_q;
    commit_s  = (state_q == S_WRITE) && (idx_q == 3'd7);
    // Full is judged on the pointers as they stand; a same-cycle release does not help.
    accept_s  = bus.lpc_valid && (state_q == S_IDLE) && !full_q;
    drop_s    = bus.lpc_valid && !accept_s;
    if (commit_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (release_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
              (wr_ptr_d[SW-1:0] == rd_ptr_d[SW-1:0]);
  end

  // Select the frame byte for the current write offset.
  always_comb begin
    ram_we_s  = (state_q == S_WRITE);
    wr_addr_s = {wr_ptr_q[SW-1:0], idx_q};
    case (idx_q)
      3'd0:    wr_byte_s = {cyc_q, ovf_mark_q, 3'b000};
      3'd1:    wr_byte_s = addr_q[31:24];
      3'd2:    wr_byte_s = addr_q[23:16];
      3'd3:    wr_byte_s = addr_q[15:8];
      3'd4:    wr_byte_s = addr_q[7:0];
      3'd5:    wr_byte_s = data_q;
      3'd6:    wr_byte_s = seq_byte_s;
      default: wr_byte_s = 8'h00;
    endcase
  end

  // Write FSM, ring pointers, flags and drop accounting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      cyc_q       <= 4'h0;
      addr_q      <= 32'h0000_0000;
      data_q      <= 8'h00;
      ovf_mark_q  <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      read_done_q <= 1'b1;  // a level already high after reset is not a release
      overflow_q  <= 1'b0;
      dropped_q   <= 8'h00;
`ifdef LPC_FRAME_SEQ_EN
      seq_cnt_q   <= 8'h00;
      seq_q       <= 8'h00;
`endif
    end else begin
      read_done_q <= bus.read_done;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      empty_q     <= empty_d;
      full_q      <= full_d;

      if (drop_s) begin
        overflow_q <= 1'b1;
        if (dropped_q != 8'hFF) begin
          dropped_q <= dropped_q + 8'd1;
        end
      end

      // A drop in the same cycle as byte 0 is written must survive for the next frame.
      if (drop_s) begin
        ovf_mark_q <= 1'b1;
      end else if ((state_q == S_WRITE) && (idx_q == 3'd0)) begin
        ovf_mark_q <= 1'b0;
      end

`ifdef LPC_FRAME_SEQ_EN
      if (bus.lpc_valid) begin
        seq_cnt_q <= seq_cnt_q + 8'd1;
      end
      if (accept_s) begin
        seq_q <= seq_cnt_q;
      end
`endif

      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            cyc_q   <= bus.lpc_cyctype_dir;
            addr_q  <= bus.lpc_addr;
            data_q  <= bus.lpc_data;
            idx_q   <= 3'd0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= 3'd0;
        end
      endcase
    end
  end

  // Frame RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram_q[wr_addr_s] <= wr_byte_s;
    end
  end

  // Registered byte read port for the drain stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data_q <= 8'h00;
    end else begin
      read_data_q <= ram_q[bus.read_addr];
    end
  end

  assign bus.read_data     = read_data_q;
  assign bus.target_addr   = rd_ptr_q[SW-1:0];
  assign bus.read_empty    = empty_q;
  assign bus.overflow      = overflow_q;
  assign bus.dropped_count = dropped_q;

endmodule

// File: tb/tb_lpc_frame_buffer.sv
// tb_lpc_frame_buffer
//   Self-checking bench for lpc_frame_buffer at AW=5 (4 slots). A queue of
//   committed frames plus a write-busy countdown serves as the reference.
`timescale 1ns/1ps
module tb_lpc_frame_buffer;
  localparam int AW    = 5;
  localparam int SLOTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lpc_frame_buffer_if #(.AW(AW)) bus ();

  lpc_frame_buffer #(.AW(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] m_q[$];      // committed frames, byte k at [8k +: 8]
  logic [63:0] m_pend;
  int          m_rd_slot;
  int          m_busy;       // edges left until the pending frame commits
  bit          m_ovf;
  bit          m_mark;
  bit          m_prev_done;
  int          m_drop;
  int          m_seq;

  task automatic model_reset();
    m_q.delete();
    m_pend      = 64'h0;
    m_rd_slot   = 0;
    m_busy      = 0;
    m_ovf       = 1'b0;
    m_mark      = 1'b0;
    m_prev_done = 1'b1;
    m_drop      = 0;
    m_seq       = 0;
  endtask

  // Advance the reference by one clock edge with the current inputs, then step the DUT.
  task automatic tick();
    bit         rise, busy_pre, full_pre;
    logic [7:0] seqb;
    if (rst) begin
      model_reset();
    end else begin
      rise        = bus.read_done && !m_prev_done;
      m_prev_done = bus.read_done;
      busy_pre    = (m_busy > 0);
      full_pre    = (m_q.size() == SLOTS);
      if (rise && m_q.size() > 0) begin
        void'(m_q.pop_front());
        m_rd_slot = (m_rd_slot + 1) % SLOTS;
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_q.push_back(m_pend);
      end
      if (bus.lpc_valid) begin
`ifdef LPC_FRAME_SEQ_EN
        seqb = 8'(m_seq);
`else
        seqb = 8'h00;
`endif
        m_seq = (m_seq + 1) % 256;
        if (busy_pre || full_pre) begin
          m_ovf  = 1'b1;
          m_mark = 1'b1;
          if (m_drop < 255) m_drop++;
        end else begin
          m_pend = {8'h00, seqb, bus.lpc_data,
                    bus.lpc_addr[7:0], bus.lpc_addr[15:8],
                    bus.lpc_addr[23:16], bus.lpc_addr[31:24],
                    bus.lpc_cyctype_dir, m_mark, 3'b000};
          m_mark = 1'b0;
          m_busy = 8;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cyc, input logic [31:0] addr, input logic [7:0] data);
    bus.lpc_valid       = 1'b1;
    bus.lpc_cyctype_dir = cyc;
    bus.lpc_addr        = addr;
    bus.lpc_data        = data;
    tick();
    bus.lpc_valid = 1'b0;
  endtask

  task automatic send_random();
    send(4'($urandom), $urandom, 8'($urandom));
  endtask

  task automatic pulse_release();
    bus.read_done = 1'b1;
    tick();
    bus.read_done = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data: got %0h expected 00", bus.read_data); end
    rst = 1'b0;
    checks++; if (bus.read_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", bus.read_empty); end
    checks++; if (bus.target_addr !== 2'd0) begin errors++; $display("FAIL reset_target: got %0d expected 0", bus.target_addr); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", bus.overflow); end
    checks++; if (bus.dropped_count !== 8'h00) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", bus.dropped_count); end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [8];
    exp_b = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h80, 8'h5A, 8'h00, 8'h00};
    send(4'h2, 32'h0000_0080, 8'h5A);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (bus.read_empty !== 1'b1) begin errors++; $display("FAIL single_empty_T8: got %0b expected 1", bus.read_empty); end
    tick();
    checks++; if (bus.read_empty !== 1'b0) begin errors++; $display("FAIL single_empty_T9: got %0b expected 0", bus.read_empty); end
    checks++; if (bus.target_addr !== 2'd0) begin errors++; $display("FAIL single_target: got %0d expected 0", bus.target_addr); end
    for (int k = 0; k < 8; k++) begin
      bus.read_addr = 5'({2'd0, 3'(k)});
      tick();
      checks++; if (bus.read_data !== exp_b[k]) begin errors++; $display("FAIL single_byte%0d: got %0h expected %0h", k, bus.read_data, exp_b[k]); end
    end
  endtask

  task automatic test_release();
    bus.read_done = 1'b1;
    tick();
    checks++; if (bus.read_empty !== 1'b1) begin errors++; $display("FAIL release_empty: got %0b expected 1", bus.read_empty); end
    checks++; if (bus.target_addr !== 2'd1) begin errors++; $display("FAIL release_target: got %0d expected 1", bus.target_addr); end
    for (int i = 0; i < 9; i++) tick();
    checks++; if (bus.target_addr !== 2'd1) begin errors++; $display("FAIL release_hold_target: got %0d expected 1", bus.target_addr); end
    bus.read_done = 1'b0;
    tick();
    bus.read_done = 1'b1;
    tick();
    checks++; if (bus.target_addr !== 2'd1) begin errors++; $display("FAIL release_when_empty: got %0d expected 1", bus.target_addr); end
    checks++; if (bus.read_empty !== 1'b1) begin errors++; $display("FAIL release_when_empty_flag: got %0b expected 1", bus.read_empty); end
    bus.read_done = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int last_slot;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_random();
      for (int j = 0; j < 9; j++) tick();
    end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", bus.overflow); end
    checks++; if (bus.dropped_count !== 8'd1) begin errors++; $display("FAIL ovf_count: got %0d expected 1", bus.dropped_count); end
    pulse_release();
    send_random();
    for (int j = 0; j < 9; j++) tick();
    last_slot = (m_rd_slot + SLOTS - 1) % SLOTS;
    bus.read_addr = 5'({2'(last_slot), 3'd0});
    tick();
    checks++; if (bus.read_data[3] !== 1'b1) begin errors++; $display("FAIL ovf_mark_bit: got %0b expected 1", bus.read_data[3]); end
`ifdef LPC_FRAME_SEQ_EN
    bus.read_addr = 5'({2'(last_slot), 3'd6});
    tick();
    checks++; if (bus.read_data !== 8'h05) begin errors++; $display("FAIL ovf_seq: got %0h expected 05", bus.read_data); end
`endif
    for (int f = 0; f < SLOTS; f++) begin
      checks++; if (bus.target_addr !== 2'(m_rd_slot)) begin errors++; $display("FAIL ovf_drain_target: got %0d expected %0d", bus.target_addr, m_rd_slot); end
      for (int k = 0; k < 8; k++) begin
        bus.read_addr = 5'({2'(m_rd_slot), 3'(k)});
        tick();
        checks++; if (bus.read_data !== m_q[0][8*k +: 8]) begin errors++; $display("FAIL ovf_drain_byte%0d: got %0h expected %0h", k, bus.read_data, m_q[0][8*k +: 8]); end
      end
      pulse_release();
    end
    checks++; if (bus.read_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty: got %0b expected 1", bus.read_empty); end
  endtask

  task automatic test_busy_drop();
    do_reset();
    send(4'h6, 32'h1234_5678, 8'hC3);
    tick();
    tick();
    send_random();
    for (int j = 0; j < 8; j++) tick();
    checks++; if (bus.dropped_count !== 8'd1) begin errors++; $display("FAIL busy_count: got %0d expected 1", bus.dropped_count); end
    checks++; if (bus.read_empty !== 1'b0) begin errors++; $display("FAIL busy_empty: got %0b expected 0", bus.read_empty); end
    for (int k = 0; k < 8; k++) begin
      bus.read_addr = 5'({2'd0, 3'(k)});
      tick();
      checks++; if (bus.read_data !== m_q[0][8*k +: 8]) begin errors++; $display("FAIL busy_byte%0d: got %0h expected %0h", k, bus.read_data, m_q[0][8*k +: 8]); end
    end
  endtask

  task automatic test_back_to_back();
    int         sent;
    int         k;
    bit         has_exp;
    logic [7:0] exp;
    do_reset();
    send_random();
    for (int j = 0; j < 9; j++) tick();
    // second frame commits in the very cycle the first is released
    send_random();
    for (int j = 0; j < 7; j++) tick();
    bus.read_done = 1'b1;
    tick();
    bus.read_done = 1'b0;
    checks++; if (bus.read_empty !== 1'b0) begin errors++; $display("FAIL coincide_empty: got %0b expected 0", bus.read_empty); end
    checks++; if (bus.target_addr !== 2'd1) begin errors++; $display("FAIL coincide_target: got %0d expected 1", bus.target_addr); end
    sent = 2;
    for (int c = 0; c < 400; c++) begin
      if (sent < 9 && $urandom_range(0, 3) == 0) begin
        bus.lpc_valid       = 1'b1;
        bus.lpc_cyctype_dir = 4'($urandom);
        bus.lpc_addr        = $urandom;
        bus.lpc_data        = 8'($urandom);
        sent++;
      end
      if ($urandom_range(0, 11) == 0) bus.read_done = ~bus.read_done;
      if (c > 300) bus.read_done = ~bus.read_done;
      k = $urandom_range(0, 7);
      bus.read_addr = 5'({2'(m_rd_slot), 3'(k)});
      has_exp = (m_q.size() > 0);
      exp = has_exp ? m_q[0][8*k +: 8] : 8'h00;
      tick();
      bus.lpc_valid = 1'b0;
      checks++; if (bus.read_empty !== (m_q.size() == 0)) begin errors++; $display("FAIL wrap_empty c%0d: got %0b expected %0b", c, bus.read_empty, m_q.size() == 0); end
      checks++; if (bus.target_addr !== 2'(m_rd_slot)) begin errors++; $display("FAIL wrap_target c%0d: got %0d expected %0d", c, bus.target_addr, m_rd_slot); end
      checks++; if (bus.dropped_count !== 8'(m_drop)) begin errors++; $display("FAIL wrap_dropped c%0d: got %0d expected %0d", c, bus.dropped_count, m_drop); end
      checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL wrap_overflow c%0d: got %0b expected %0b", c, bus.overflow, m_ovf); end
      if (has_exp) begin
        checks++; if (bus.read_data !== exp) begin errors++; $display("FAIL wrap_data c%0d: got %0h expected %0h", c, bus.read_data, exp); end
      end
    end
    bus.read_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    send_random();
    tick();
    send_random();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.read_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %0b expected 1", bus.read_empty); end
    checks++; if (bus.dropped_count !== 8'd0) begin errors++; $display("FAIL midrst_dropped: got %0d expected 0", bus.dropped_count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %0b expected 0", bus.overflow); end
    for (int j = 0; j < 10; j++) tick();
    checks++; if (bus.read_empty !== 1'b1) begin errors++; $display("FAIL midrst_no_commit: got %0b expected 1", bus.read_empty); end
    send_random();
    for (int j = 0; j < 8; j++) tick();
    checks++; if (bus.read_empty !== 1'b0) begin errors++; $display("FAIL midrst_next_empty: got %0b expected 0", bus.read_empty); end
    checks++; if (bus.target_addr !== 2'd0) begin errors++; $display("FAIL midrst_next_target: got %0d expected 0", bus.target_addr); end
    for (int k = 0; k < 8; k++) begin
      bus.read_addr = 5'({2'd0, 3'(k)});
      tick();
      checks++; if (bus.read_data !== m_q[0][8*k +: 8]) begin errors++; $display("FAIL midrst_byte%0d: got %0h expected %0h", k, bus.read_data, m_q[0][8*k +: 8]); end
    end
  endtask

  initial begin
    bus.lpc_valid       = 1'b0;
    bus.lpc_cyctype_dir = 4'h0;
    bus.lpc_addr        = 32'h0;
    bus.lpc_data        = 8'h00;
    bus.read_addr       = 5'd0;
    bus.read_done       = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_release();
    test_overflow();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpc_frame_buffer.md
# lpc_frame_buffer

- Captures each decoded LPC cycle and stores it as one 8-byte frame in an internal ring of frame slots.
- Exposes the oldest committed frame to the serial drain stage: `read_empty`, `target_addr`, a byte read port, and the `read_done` release.
- Sits between the LPC bus decoder and the memory-to-UART serializer.
- Counts and flags cycles lost to a full ring.

## Interface

Parameters
- `AW`, default 8: byte address width of the frame RAM.
  - Slot count is 2^(AW-3); each slot is 8 bytes.

Ports
- `clock`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high reset.
- `lpc_valid`, in, 1: one-cycle pulse; the fields below are valid in that cycle.
- `lpc_cyctype_dir`, in, 4: cycle type and direction code.
- `lpc_addr`, in, 32: cycle address.
- `lpc_data`, in, 8: cycle data byte.
- `read_addr`, in, AW: byte address from the drain stage.
- `read_data`, out, 8: RAM byte at `read_addr`, registered.
- `target_addr`, out, AW-3: slot index of the oldest committed frame.
- `read_empty`, out, 1: high when no committed frame is pending.
- `read_done`, in, 1: level from the drain stage; its rising edge releases the current frame.
- `overflow`, out, 1: sticky; set on the first dropped cycle, cleared only by reset.
- `dropped_count`, out, 8: count of dropped cycles, saturating at 255.

## Operation

- Frame layout, byte offsets 0 to 7 within a slot:
  - 0: `{cyctype_dir[3:0], ovf_mark, 3'b000}`.
    - `ovf_mark` is 1 if at least one cycle was dropped since the previous stored frame. It is cleared once written.
  - 1 to 4: `lpc_addr[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - 5: `lpc_data`.
  - 6: sequence byte (see Configuration).
  - 7: 8'h00.
- The drain stage consumes offsets 0 to 6 only. Offset 7 is always written so the slot contents are deterministic.
- Pointers `wr_ptr` and `rd_ptr` are each AW-2 bits wide: the slot index plus one wrap bit.
  - Empty: `wr_ptr == rd_ptr`.
  - Full: the wrap bits differ and the slot indices are equal.
- `target_addr` = `rd_ptr[AW-4:0]`. `read_empty` is the registered empty flag.
- Write FSM states:
  - IDLE:
    - On `lpc_valid` with the ring full: drop the cycle, set `overflow`, set `ovf_mark`, and increment `dropped_count` unless it is at 255. Stay in IDLE.
    - On `lpc_valid` with the ring not full: latch all fields and go to WRITE with byte index 0.
  - WRITE:
    - Write one byte per cycle to `{wr_ptr[AW-4:0], idx}`, idx running 0 to 7.
    - On idx 7: `wr_ptr <= wr_ptr + 1` and return to IDLE.
- `lpc_valid` arriving in WRITE is dropped and counted exactly as in the full case. The decoder's minimum cycle spacing exceeds 8 clocks, so this is an error path.
- Release:
  - Register `read_done` as `read_done_q`.
  - A rising edge (`read_done & ~read_done_q`) while not empty does `rd_ptr <= rd_ptr + 1`.
  - A rising edge while empty is ignored.
- A commit and a release in the same cycle both take effect.
  - The empty and full flags are computed from the post-update pointers.
- The full check on `lpc_valid` uses the pointers as they are in that cycle. A release in the same cycle does not rescue the cycle; it is dropped.
- The slot being written is never the slot being read: writes happen only when not full, and a slot is readable only after commit. No read/write collision handling is needed.

## Timing

- `lpc_valid` accepted at cycle T: bytes 0 to 7 are written in cycles T+1 to T+8.
  - `wr_ptr` updates at the end of T+8.
  - `read_empty` falls in cycle T+9 if the ring was empty.
- `read_data`: one-cycle latency from `read_addr`.
- Release: a `read_done` rising edge in cycle R gives the new `target_addr` and `read_empty` in cycle R+1.
- Reset values:
  - `read_empty` = 1, `target_addr` = 0, `overflow` = 0, `dropped_count` = 0, `read_data` = 0.
  - `read_done_q` = 1, so a high `read_done` right after reset is not treated as a release.
  - Pointers = 0, FSM = IDLE, `ovf_mark` = 0, sequence counter = 0.
- Reset during WRITE:
  - The partial frame is abandoned and never committed.
  - RAM contents are not cleared.
- Pointer wrap-around is natural modulo 2^(AW-2).

## Configuration

- `LPC_FRAME_SEQ_EN` defined:
  - Offset 6 holds an 8-bit sequence counter.
  - The counter increments, wrapping, on every `lpc_valid`, including dropped cycles.
  - Gaps in the sequence identify lost cycles on the host.
- `LPC_FRAME_SEQ_EN` undefined:
  - Offset 6 is 8'h00 and no counter is instantiated.

## Test plan

- Single cycle into an empty ring:
  - Stimulus: `lpc_valid` with cyctype 4'h2, addr 32'h0000_0080, data 8'h5A.
  - Required: `read_empty` falls at T+9, `target_addr` = 0.
  - Required: reads of offsets 0 to 7 return 20, 00, 00, 00, 80, 5A, 00 (seq; 00 without the macro), 00.
- Release and empty:
  - Stimulus: raise `read_done` and hold it high for 10 cycles.
  - Required: exactly one release, `read_empty` = 1 at R+1, `target_addr` = 1.
  - Stimulus: a second rising edge while empty.
  - Required: no pointer change.
- Fill and overflow at AW=5 (4 slots):
  - Stimulus: 5 cycles, no releases.
  - Required: 5th dropped; `overflow` = 1, `dropped_count` = 1.
  - Stimulus: release one, then send one more.
  - Required: the new frame's byte 0 has bit 3 set; with the macro, its sequence byte is 8'h05.
- Busy drop:
  - Stimulus: second `lpc_valid` at T+3.
  - Required: dropped, `dropped_count` increments, first frame intact.
- Wrap plus simultaneous events:
  - Stimulus: 9 frames through 4 slots, with one commit coinciding with a release.
  - Required: FIFO order preserved; `read_empty` and full flags correct each cycle.
- Reset mid-WRITE:
  - Stimulus: `reset` at T+4.
  - Required: `read_empty` = 1 and all counters 0 afterwards; the next frame goes to slot 0.
